// File: rtl/stopwatch_bcd.sv
// BCD stopwatch (MM:SS.t) advanced by rising edges of a synchronized 100 ms tick.
// Define STOPWATCH_LAP_EN to add the lap input, lap_active output and lap hold registers.
module stopwatch_bcd #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_MIN     = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap,
  output logic       lap_active,
`endif
  output logic       running,
  output logic [3:0] tenths,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       overflow
);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_t;

  localparam logic [3:0] MinTensMax = 4'(MAX_MIN / 10);
  localparam logic [3:0] MinOnesMax = 4'(MAX_MIN % 10);

  state_t state_q;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   tick_pulse;

  logic [3:0] t_q, so_q, st_q, mo_q, mt_q;
  logic [3:0] t_d, so_d, st_d, mo_d, mt_d;
  logic       wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= tick_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      sync_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick_pulse = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

  // Ripple-carry BCD increment of the live count; wrap flags MAX_MIN:59.9 -> 00:00.0.
  always_comb begin
    t_d  = t_q;
    so_d = so_q;
    st_d = st_q;
    mo_d = mo_q;
    mt_d = mt_q;
    wrap = 1'b0;
    if (t_q != 4'd9) begin
      t_d = t_q + 4'd1;
    end else begin
      t_d = 4'd0;
      if (so_q != 4'd9) begin
        so_d = so_q + 4'd1;
      end else begin
        so_d = 4'd0;
        if (st_q != 4'd5) begin
          st_d = st_q + 4'd1;
        end else begin
          st_d = 4'd0;
          if (mt_q == MinTensMax && mo_q == MinOnesMax) begin
            mo_d = 4'd0;
            mt_d = 4'd0;
            wrap = 1'b1;
          end else if (mo_q == 4'd9) begin
            mo_d = 4'd0;
            mt_d = mt_q + 4'd1;
          end else begin
            mo_d = mo_q + 4'd1;
          end
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [3:0] t_h_q, so_h_q, st_h_q, mo_h_q, mt_h_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      running  <= 1'b0;
      overflow <= 1'b0;
      t_q      <= '0;
      so_q     <= '0;
      st_q     <= '0;
      mo_q     <= '0;
      mt_q     <= '0;
`ifdef STOPWATCH_LAP_EN
      lap_active <= 1'b0;
      t_h_q      <= '0;
      so_h_q     <= '0;
      st_h_q     <= '0;
      mo_h_q     <= '0;
      mt_h_q     <= '0;
`endif
    end else begin
      overflow <= 1'b0;
      if (clear) begin
        state_q <= StIdle;
        running <= 1'b0;
        t_q     <= '0;
        so_q    <= '0;
        st_q    <= '0;
        mo_q    <= '0;
        mt_q    <= '0;
`ifdef STOPWATCH_LAP_EN
        lap_active <= 1'b0;
`endif
      end else begin
        // Increment eligibility uses the pre-edge state, so tick+start_stop in RUN still counts.
        if (state_q == StRun && tick_pulse) begin
          t_q      <= t_d;
          so_q     <= so_d;
          st_q     <= st_d;
          mo_q     <= mo_d;
          mt_q     <= mt_d;
          overflow <= wrap;
        end
        if (start_stop) begin
          if (state_q == StRun) begin
            state_q <= StPause;
            running <= 1'b0;
          end else begin
            state_q <= StRun;
            running <= 1'b1;
          end
        end
`ifdef STOPWATCH_LAP_EN
        if (lap && state_q == StRun) begin
          if (!lap_active) begin
            t_h_q      <= t_q;
            so_h_q     <= so_q;
            st_h_q     <= st_q;
            mo_h_q     <= mo_q;
            mt_h_q     <= mt_q;
            lap_active <= 1'b1;
          end else begin
            lap_active <= 1'b0;
          end
        end
`endif
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  assign tenths   = lap_active ? t_h_q  : t_q;
  assign sec_ones = lap_active ? so_h_q : so_q;
  assign sec_tens = lap_active ? st_h_q : st_q;
  assign min_ones = lap_active ? mo_h_q : mo_q;
  assign min_tens = lap_active ? mt_h_q : mt_q;
`else
  assign tenths   = t_q;
  assign sec_ones = so_q;
  assign sec_tens = st_q;
  assign min_ones = mo_q;
  assign min_tens = mt_q;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench for stopwatch_bcd: a default instance and a MAX_MIN=12 instance share
// stimulus; expectations come from a tenths-count model and are checked by a monitor.
module tb_stopwatch_bcd;

  localparam int MaxA = 59;
  localparam int MaxB = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_in = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;

  logic       running_a, overflow_a, running_b, overflow_b;
  logic [3:0] tenths_a, sec_ones_a, sec_tens_a, min_ones_a, min_tens_a;
  logic [3:0] tenths_b, sec_ones_b, sec_tens_b, min_ones_b, min_tens_b;
`ifdef STOPWATCH_LAP_EN
  logic lap = 1'b0;
  logic lap_active_a, lap_active_b;
`endif

  stopwatch_bcd dut_a (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
    .lap(lap), .lap_active(lap_active_a),
`endif
    .running(running_a), .tenths(tenths_a), .sec_ones(sec_ones_a), .sec_tens(sec_tens_a),
    .min_ones(min_ones_a), .min_tens(min_tens_a), .overflow(overflow_a)
  );

  stopwatch_bcd #(.SYNC_STAGES(2), .MAX_MIN(MaxB)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
    .lap(lap), .lap_active(lap_active_b),
`endif
    .running(running_b), .tenths(tenths_b), .sec_ones(sec_ones_b), .sec_tens(sec_tens_b),
    .min_ones(min_ones_b), .min_tens(min_tens_b), .overflow(overflow_b)
  );

  always #5 clk = ~clk;

  logic [21:0] act_a, act_b;
  assign act_a = {min_tens_a, min_ones_a, sec_tens_a, sec_ones_a, tenths_a, running_a, overflow_a};
  assign act_b = {min_tens_b, min_ones_b, sec_tens_b, sec_ones_b, tenths_b, running_b, overflow_b};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [21:0] ea;
    logic [21:0] eb;
  } rec_t;
  rec_t q[$];

  int total = 0;
  int bad = 0;

  // Model: mode 0=idle 1=run 2=pause; counts are elapsed tenths modulo (MAX_MIN+1) minutes.
  int mode = 0;
  int cnt_a = 0, cnt_b = 0;
  int wraps_a = 0, wraps_b = 0;
  int seen_a = 0, seen_b = 0;

  function automatic logic [21:0] exp_vec(int c, bit run, bit ovf);
    int m, s, t;
    m = c / 600;
    s = (c / 10) % 60;
    t = c % 10;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(t), run, ovf};
  endfunction

  task automatic check(string name, logic [21:0] act, logic [21:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Records landing on the same cycle merge; the later one carries the final values.
  task automatic push(int due, bit oa, bit ob);
    rec_t r;
    r.due = due;
    r.ea  = exp_vec(cnt_a, mode == 1, oa);
    r.eb  = exp_vec(cnt_b, mode == 1, ob);
    if (q.size() > 0 && q[q.size()-1].due == due) begin
      r.ea[0] = r.ea[0] | q[q.size()-1].ea[0];
      r.eb[0] = r.eb[0] | q[q.size()-1].eb[0];
      q[q.size()-1] = r;
    end else begin
      q.push_back(r);
    end
  endtask

  task automatic model_tick(output bit wa, output bit wb);
    wa = 0;
    wb = 0;
    if (mode == 1) begin
      cnt_a++;
      cnt_b++;
      if (cnt_a == (MaxA + 1) * 600) begin cnt_a = 0; wa = 1; wraps_a++; end
      if (cnt_b == (MaxB + 1) * 600) begin cnt_b = 0; wb = 1; wraps_b++; end
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick(int hi, int lo);
    int c;
    bit wa, wb;
    c = cyc;
    push(c + 2, 0, 0);
    model_tick(wa, wb);
    push(c + 3, wa, wb);
    if (wa || wb) push(c + 4, 0, 0);
    tick_in = 1'b1;
    step(hi);
    tick_in = 1'b0;
    step(lo);
  endtask

  task automatic do_ss();
    start_stop = 1'b1;
    mode = (mode == 1) ? 2 : 1;
    push(cyc + 1, 0, 0);
    step(1);
    start_stop = 1'b0;
  endtask

  task automatic do_clear(bit with_ss);
    clear = 1'b1;
    start_stop = with_ss;
    mode = 0;
    cnt_a = 0;
    cnt_b = 0;
    push(cyc + 1, 0, 0);
    step(1);
    clear = 1'b0;
    start_stop = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      step(1);
      n++;
    end
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain_timeout pending=%0d want=0", q.size());
      q.delete();
    end
  endtask

  rec_t mr;
  always @(negedge clk) begin
    if (overflow_a) seen_a++;
    if (overflow_b) seen_b++;
    while (q.size() > 0 && q[0].due <= cyc) begin
      mr = q.pop_front();
      if (mr.due < cyc) begin
        bad++;
        $display("FAIL late_record due=%0d now=%0d", mr.due, cyc);
      end else begin
        check("dut_a", act_a, mr.ea);
        check("dut_b", act_b, mr.eb);
      end
    end
  end

  initial begin
    bit wa, wb;
    int c;
    step(5);
    rst_n = 1'b1;
    push(cyc + 1, 0, 0);
    for (int i = 0; i < 4; i++) do_tick(2, 2);   // ignored in IDLE

    do_ss();
    for (int i = 0; i < 10; i++) do_tick($urandom_range(1, 3), 2);   // -> 00:01.0
    do_ss();
    for (int i = 0; i < 5; i++) do_tick(2, 1);                       // paused
    do_ss();
    do_tick(1, 2);                                                   // -> 00:01.1

    do_clear(0);
    do_ss();
    for (int i = 0; i < 34; i++) do_tick(1, 2);                      // 00:03.4
    do_clear(1);                                                     // clear beats start_stop

    do_ss();
    for (int i = 0; i < 5; i++) do_tick(1, 2);                       // 00:00.5
    c = cyc;                                                         // tick + start_stop
    push(c + 2, 0, 0);
    tick_in = 1'b1;
    step(2);
    start_stop = 1'b1;
    model_tick(wa, wb);
    mode = 2;
    push(c + 3, wa, wb);
    step(1);
    start_stop = 1'b0;
    tick_in = 1'b0;
    step(2);

    do_clear(0);
    do_ss();
    for (int i = 0; i < (MaxB + 1) * 600; i++) do_tick(1, 1);        // dut_b wraps once
    step(3);

    for (int i = 0; i < 300; i++) begin
      int r, hi;
      r = $urandom_range(0, 99);
      if (r < 75) begin
        hi = $urandom_range(1, 4);
        do_tick(hi, $urandom_range(hi >= 2 ? 1 : 2, 3));
      end else if (r < 93) begin
        do_ss();
      end else begin
        do_clear(0);
      end
    end
    step(3);

    do_clear(0);
    do_ss();
    for (int i = 0; i < 1373; i++) do_tick(1, 1);                    // 02:17.3
    step(3);
    drain();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    mode = 0;
    cnt_a = 0;
    cnt_b = 0;
    #1;
    check("async_rst_a", act_a, exp_vec(0, 0, 0));
    check("async_rst_b", act_b, exp_vec(0, 0, 0));
    step(2);
    rst_n = 1'b1;
    push(cyc + 1, 0, 0);
    do_tick(2, 2);                                                   // idle after reset
    step(2);
    drain();

    check_int("ovf_pulses_a", seen_a, wraps_a);
    check_int("ovf_pulses_b", seen_b, wraps_b);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
